// File: rtl/ddr_axi_resp_mem.sv
// ddr_axi_resp_mem
//   AXI4 slave that stands in for the DDR controller on the debug path.
//   INCR write bursts are stored in a single-port synchronous RAM and
//   returned on later read bursts, so test traffic can loop back without
//   a DDR/PHY. Exactly one burst (write or read) is in flight at a time.
//
// Ports
//   SysClk, SysRstN              clock, async active-low reset
//   AwId/AwAddr/AwLen/AwValid -> write address; AwReady back
//   WData/WStrb/WLast/WValid  -> write data;    WReady back
//   BId/BResp/BValid          <- write response; BReady in
//   ArId/ArAddr/ArLen/ArValid -> read address;  ArReady back
//   RId/RData/RResp/RLast/RValid <- read data;  RReady in
//
// Byte addresses are converted to RAM word addresses by dropping the low
// ABW bits; the word address wraps modulo the RAM depth within a burst.

// One byte lane of the backing RAM: byte-enabled write, registered read.
module ddr_axi_resp_mem_lane #(
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      SysClk,
    input  logic                      SysRstN,
    input  logic                      We,
    input  logic                      Re,
    input  logic [MEM_ADDR_WIDTH-1:0] Addr,
    input  logic [7:0]                Wd,
    output logic [7:0]                Rd
);
    logic [7:0] mem [0:(2**MEM_ADDR_WIDTH)-1];

    always_ff @(posedge SysClk) begin
        if (We) mem[Addr] <= Wd;
    end

    // Output register only loads on a read, so it holds the presented
    // beat while the master stalls.
    always_ff @(posedge SysClk or negedge SysRstN) begin
        if (!SysRstN)  Rd <= '0;
        else if (Re)   Rd <= mem[Addr];
    end
endmodule

module ddr_axi_resp_mem #(
    parameter int AXI_DATA_WIDTH = 256,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int AXI_ID_WIDTH   = 4
) (
    input  logic                        SysClk,
    input  logic                        SysRstN,
    input  logic [AXI_ID_WIDTH-1:0]     AwId,
    input  logic [31:0]                 AwAddr,
    input  logic [7:0]                  AwLen,
    input  logic                        AwValid,
    output logic                        AwReady,
    input  logic [AXI_DATA_WIDTH-1:0]   WData,
    input  logic [AXI_DATA_WIDTH/8-1:0] WStrb,
    input  logic                        WLast,
    input  logic                        WValid,
    output logic                        WReady,
    output logic [AXI_ID_WIDTH-1:0]     BId,
    output logic [1:0]                  BResp,
    output logic                        BValid,
    input  logic                        BReady,
    input  logic [AXI_ID_WIDTH-1:0]     ArId,
    input  logic [31:0]                 ArAddr,
    input  logic [7:0]                  ArLen,
    input  logic                        ArValid,
    output logic                        ArReady,
    output logic [AXI_ID_WIDTH-1:0]     RId,
    output logic [AXI_DATA_WIDTH-1:0]   RData,
    output logic [1:0]                  RResp,
    output logic                        RLast,
    output logic                        RValid,
    input  logic                        RReady
);
    localparam int ABN = AXI_DATA_WIDTH / 8;
    localparam int ABW = $clog2(ABN);
    localparam int MAW = MEM_ADDR_WIDTH;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t                  state;
    logic                    idleRdy;   // registered "accepting a new burst"
    logic [AXI_ID_WIDTH-1:0] idQ;
    logic [7:0]              lenQ;
    logic [7:0]              beatCnt;
    logic [MAW-1:0]          addrQ;     // next RAM word to write or read
    logic                    wrErr;
    logic                    wReadyQ;
    logic                    bValidQ;
    logic [1:0]              bRespQ;
    logic                    rValidQ;
    logic                    rLastQ;

    logic awHs, arHs, wHs, rHs, lastBeat, lastMiss;
    logic ramWe, ramRe;
    logic [ABN-1:0][7:0] ramQ;
    logic unusedAddrBits;

    // Write wins a same-cycle AW/AR collision, hence ArReady sees AwValid.
    assign AwReady  = idleRdy;
    assign ArReady  = idleRdy & ~AwValid;
    assign WReady   = wReadyQ;
    assign BValid   = bValidQ;
    assign BResp    = bRespQ;
    assign BId      = idQ;
    assign RId      = idQ;
    assign RValid   = rValidQ;
    assign RLast    = rLastQ;
    assign RResp    = 2'b00;
    assign RData    = ramQ;

    assign awHs     = AwValid & idleRdy;
    assign arHs     = ArValid & ArReady;
    assign wHs      = WValid & wReadyQ;
    assign rHs      = rValidQ & RReady;
    assign lastBeat = (beatCnt == lenQ);
    assign lastMiss = (WLast != lastBeat);

    // RD_ADDR fetches beat 0; each R handshake fetches the following beat
    // in the same cycle so a continuously-ready master sees no bubbles.
    assign ramWe = wHs;
    assign ramRe = (state == RD_ADDR) | ((state == RD_DATA) & rHs & ~rLastQ);

    // Byte offset and upper address bits carry no meaning for this RAM.
    assign unusedAddrBits = ^{AwAddr, ArAddr};

    for (genvar i = 0; i < ABN; i++) begin : gLane
        ddr_axi_resp_mem_lane #(.MEM_ADDR_WIDTH(MAW)) uLane (
            .SysClk  (SysClk),
            .SysRstN (SysRstN),
            .We      (ramWe & WStrb[i]),
            .Re      (ramRe),
            .Addr    (addrQ),
            .Wd      (WData[i*8 +: 8]),
            .Rd      (ramQ[i])
        );
    end

    always_ff @(posedge SysClk or negedge SysRstN) begin
        if (!SysRstN) begin
            state   <= IDLE;
            idleRdy <= 1'b0;
            idQ     <= '0;
            lenQ    <= '0;
            beatCnt <= '0;
            addrQ   <= '0;
            wrErr   <= 1'b0;
            wReadyQ <= 1'b0;
            bValidQ <= 1'b0;
            bRespQ  <= 2'b00;
            rValidQ <= 1'b0;
            rLastQ  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    idleRdy <= 1'b1;
                    if (awHs) begin
                        idQ     <= AwId;
                        lenQ    <= AwLen;
                        addrQ   <= AwAddr[ABW +: MAW];
                        beatCnt <= '0;
                        wrErr   <= 1'b0;
                        idleRdy <= 1'b0;
                        wReadyQ <= 1'b1;
                        state   <= WR_DATA;
                    end else if (arHs) begin
                        idQ     <= ArId;
                        lenQ    <= ArLen;
                        addrQ   <= ArAddr[ABW +: MAW];
                        beatCnt <= '0;
                        idleRdy <= 1'b0;
                        state   <= RD_ADDR;
                    end
                end
                WR_DATA: begin
                    if (wHs) begin
                        addrQ   <= addrQ + MAW'(1);
                        beatCnt <= beatCnt + 8'd1;
                        if (lastMiss) wrErr <= 1'b1;
                        // Burst length comes from AwLen only; WLast just
                        // feeds the error flag.
                        if (lastBeat) begin
                            wReadyQ <= 1'b0;
                            bValidQ <= 1'b1;
                            bRespQ  <= (wrErr | lastMiss) ? 2'b10 : 2'b00;
                            state   <= WR_RESP;
                        end
                    end
                end
                WR_RESP: begin
                    if (BReady) begin
                        bValidQ <= 1'b0;
                        bRespQ  <= 2'b00;
                        wrErr   <= 1'b0;
                        idleRdy <= 1'b1;
                        state   <= IDLE;
                    end
                end
                RD_ADDR: begin
                    addrQ   <= addrQ + MAW'(1);
                    rValidQ <= 1'b1;
                    rLastQ  <= (lenQ == 8'd0);
                    beatCnt <= '0;
                    state   <= RD_DATA;
                end
                RD_DATA: begin
                    if (rHs) begin
                        if (rLastQ) begin
                            rValidQ <= 1'b0;
                            rLastQ  <= 1'b0;
                            idleRdy <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            addrQ   <= addrQ + MAW'(1);
                            beatCnt <= beatCnt + 8'd1;
                            rLastQ  <= ((beatCnt + 8'd1) == lenQ);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
